// File: rtl/result_display.sv
// Purpose : ALU front-panel output stage; latches result/op/flags on a debounced-free "show"
//           press and time-multiplexes them as hex digits onto a 4-digit common-anode display.
// Latency : capture lands on the 3rd clk edge after update rises; seg_n/dp_n/an_n are registered,
//           1 clk after the scan state they reflect. No backpressure (free-running display).
// Ports   : clk, rst_n (async active-low); result[7:0], op[5:0], carry, zero, update (raw button);
//           seg_n[6:0] {g..a}, dp_n, an_n[3:0] (an_n[0] rightmost), all active-low; shown[7:0], valid.
// Option  : define LEADING_ZERO_BLANK_EN to blank a zero high nibble of the result (idx1) and a zero
//           op[5:4] digit (idx3) once something has been captured.
module result_display #(
   parameter int SCAN_DIV = 50000,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] result,
   input  logic [5:0]        op,
   input  logic              carry,
   input  logic              zero,
   input  logic              update,
   output logic [6:0]        seg_n,
   output logic              dp_n,
   output logic [3:0]        an_n,
   output logic [DATA_W-1:0] shown,
   output logic              valid
);

   localparam int               CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   // Active-low hex font, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------
   // Button synchronizer and rising-edge detect. upd_s3 is the delayed
   // copy used only for edge detection, so a held button fires once.
   // ---------------------------------------------------------------
   logic upd_s1, upd_s2, upd_s3;
   logic cap_stb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_s1 <= 1'b0;
         upd_s2 <= 1'b0;
         upd_s3 <= 1'b0;
      end else begin
         upd_s1 <= update;
         upd_s2 <= upd_s1;
         upd_s3 <= upd_s2;
      end
   end

   assign cap_stb = upd_s2 & ~upd_s3;

   // ---------------------------------------------------------------
   // Capture registers: all fields load together so the panel never
   // shows a result paired with a different operation's flags.
   // ---------------------------------------------------------------
   logic [5:0] op_q;
   logic       carry_q;
   logic       zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shown   <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         valid   <= 1'b0;
      end else if (cap_stb) begin
         shown   <= result;
         op_q    <= op;
         carry_q <= carry;
         zero_q  <= zero;
         valid   <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Scan timing: one slot per digit, digit index steps at terminal count.
   // ---------------------------------------------------------------
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       dig_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
      end else if (scan_cnt == CNT_MAX) begin
         scan_cnt <= '0;
         dig_idx  <= dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Next display word. The anodes are all off on count 0 of each slot so
   // the previous digit's segments never flash on the next anode.
   // ---------------------------------------------------------------
   logic [3:0] nib;
   logic [6:0] seg_d;
   logic       dp_d;
   logic [3:0] an_d;

   always_comb begin
      nib   = 4'h0;
      seg_d = 7'h3F;   // dash until the first capture
      dp_d  = 1'b1;
      an_d  = (scan_cnt == '0) ? 4'hF : ~(4'b0001 << dig_idx);

      case (dig_idx)
         2'd0:    nib = shown[3:0];
         2'd1:    nib = shown[7:4];
         2'd2:    nib = op_q[3:0];
         default: nib = {2'b00, op_q[5:4]};
      endcase

      if (valid) begin
         seg_d = hex_to_seg(nib);
         if ((dig_idx == 2'd0) && zero_q)  dp_d = 1'b0;
         if ((dig_idx == 2'd1) && carry_q) dp_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         // Only segments are blanked; a lit carry dp on idx1 survives.
         if (((dig_idx == 2'd1) || (dig_idx == 2'd3)) && (nib == 4'h0))
            seg_d = 7'h7F;
`endif
      end
   end

   // Registered pins: segments, dp and anodes switch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
         an_n  <= 4'hF;
      end else begin
         seg_n <= seg_d;
         dp_n  <= dp_d;
         an_n  <= an_d;
      end
   end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

   logic       clk;
   logic       rst_n;
   logic [7:0] result;
   logic [5:0] op;
   logic       carry;
   logic       zero;
   logic       update;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [3:0] an_n;
   logic [7:0] shown;
   logic       valid;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [7:0] res;
      logic [5:0] op;
      logic       c;
      logic       z;
   } cap_t;

   cap_t sb[$];
   cap_t cur;

   result_display #(.SCAN_DIV(4), .DATA_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .result (result),
      .op     (op),
      .carry  (carry),
      .zero   (zero),
      .update (update),
      .seg_n  (seg_n),
      .dp_n   (dp_n),
      .an_n   (an_n),
      .shown  (shown),
      .valid  (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] ZSEG = 7'h7F;
`else
   localparam logic [6:0] ZSEG = 7'h40;
`endif

   // Step negedge by negedge until digit i is lit; ok=0 if it never is.
   task automatic wait_digit(input int i, output bit ok);
      logic [3:0] sel;
      sel = ~(4'b0001 << i);
      ok  = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (an_n == sel) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Drive one press of the button with the given ALU state and log the
   // expected capture; leaves the button released long enough to re-arm.
   task automatic do_capture(input logic [7:0] r, input logic [5:0] o,
                             input logic c, input logic z);
      cap_t e;
      @(negedge clk);
      result = r; op = o; carry = c; zero = z; update = 1'b1;
      e.res = r; e.op = o; e.c = c; e.z = z;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      update = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_total++;
      if ({an_n, seg_n, dp_n, valid, shown} !== {4'hF, 7'h7F, 1'b1, 1'b0, 8'h00})
         $display("FAIL reset_state: an=%h seg=%h dp=%b valid=%b shown=%h, want F 7f 1 0 00",
                  an_n, seg_n, dp_n, valid, shown);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   // Starts on the negedge reset was released.
   task automatic test_scan;
      logic [3:0] exp_an;
      logic [3:0] one;
      int c, x;
      one = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         c = (k - 1) % 4;
         x = ((k - 1) / 4) % 4;
         exp_an = (c == 0) ? 4'hF : ~(one << x);
         n_total++;
         if (an_n !== exp_an)
            $display("FAIL scan_an k=%0d: an_n=%h want %h", k, an_n, exp_an);
         else n_pass++;
         if (an_n != 4'hF) begin
            n_total++;
            if (seg_n !== 7'h3F || dp_n !== 1'b1)
               $display("FAIL dash k=%0d: seg=%h dp=%b want 3f 1", k, seg_n, dp_n);
            else n_pass++;
         end
      end
   endtask

   task automatic test_capture;
      logic [6:0] es [4];
      logic       ed [4];
      bit ok;
      es = '{7'h12, 7'h08, 7'h30, 7'h24};
      ed = '{1'b1, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      result = 8'hA5; op = 6'h23; carry = 1'b1; zero = 1'b0; update = 1'b1;
      sb.push_back('{res: 8'hA5, op: 6'h23, c: 1'b1, z: 1'b0});
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_total++;
      if (valid !== 1'b0 || shown !== 8'h00)
         $display("FAIL cap_early: valid=%b shown=%h after 2 edges, want 0 00", valid, shown);
      else n_pass++;
      @(posedge clk); @(negedge clk);
      cur = sb.pop_front();
      n_total++;
      if (valid !== 1'b1 || shown !== cur.res)
         $display("FAIL cap_edge3: valid=%b shown=%h, want 1 %h", valid, shown, cur.res);
      else n_pass++;
      repeat (2) @(negedge clk);
      update = 1'b0;
      // ALU moving on after the capture must not disturb the panel.
      result = 8'hFF; op = 6'h3F; zero = 1'b1; carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_digit(i, ok);
         n_total++;
         if (!ok || seg_n !== es[i] || dp_n !== ed[i])
            $display("FAIL cap_digit%0d: found=%b seg=%h dp=%b want %h %b",
                     i, ok, seg_n, dp_n, es[i], ed[i]);
         else n_pass++;
      end
      n_total++;
      if (shown !== 8'hA5)
         $display("FAIL cap_hold: shown=%h want a5", shown);
      else n_pass++;
   endtask

   task automatic test_flags;
      logic [6:0] es [4];
      logic       ed [4];
      bit ok;
      es = '{7'h40, ZSEG, 7'h12, 7'h79};
      ed = '{1'b0, 1'b1, 1'b1, 1'b1};
      do_capture(8'h00, 6'h15, 1'b0, 1'b1);
      cur = sb.pop_front();
      n_total++;
      if (shown !== cur.res)
         $display("FAIL flags_shown: shown=%h want %h", shown, cur.res);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         wait_digit(i, ok);
         n_total++;
         if (!ok || seg_n !== es[i] || dp_n !== ed[i])
            $display("FAIL flags_digit%0d: found=%b seg=%h dp=%b want %h %b",
                     i, ok, seg_n, dp_n, es[i], ed[i]);
         else n_pass++;
      end
   endtask

   task automatic test_single_capture;
      @(negedge clk);
      result = 8'h00; op = 6'h2A; carry = 1'b0; zero = 1'b0; update = 1'b1;
      // Result steps every clk; the 3rd edge after the rise samples value 2.
      sb.push_back('{res: 8'h02, op: 6'h2A, c: 1'b0, z: 1'b0});
      for (int i = 1; i < 100; i++) begin
         @(negedge clk);
         result = 8'(i);
      end
      @(negedge clk);
      cur = sb.pop_front();
      n_total++;
      if (shown !== cur.res)
         $display("FAIL held_once: shown=%h want %h", shown, cur.res);
      else n_pass++;
      update = 1'b0;
      repeat (3) @(negedge clk);
      result = 8'h7E; update = 1'b1;
      sb.push_back('{res: 8'h7E, op: 6'h2A, c: 1'b0, z: 1'b0});
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_total++;
      if (shown !== 8'h02)
         $display("FAIL repress_early: shown=%h want 02", shown);
      else n_pass++;
      @(posedge clk); @(negedge clk);
      cur = sb.pop_front();
      n_total++;
      if (shown !== cur.res)
         $display("FAIL repress: shown=%h want %h", shown, cur.res);
      else n_pass++;
      update = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_leading_zero;
      logic [6:0] es [4];
      logic       ed [4];
      bit ok;
      es = '{7'h12, ZSEG, 7'h30, ZSEG};
      ed = '{1'b1, 1'b1, 1'b1, 1'b1};
      do_capture(8'h05, 6'h03, 1'b0, 1'b0);
      cur = sb.pop_front();
      n_total++;
      if (shown !== cur.res)
         $display("FAIL lz_shown: shown=%h want %h", shown, cur.res);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         wait_digit(i, ok);
         n_total++;
         if (!ok || seg_n !== es[i] || dp_n !== ed[i])
            $display("FAIL lz_digit%0d: found=%b seg=%h dp=%b want %h %b",
                     i, ok, seg_n, dp_n, es[i], ed[i]);
         else n_pass++;
      end
      // Zero high nibble with carry: dp must stay lit whatever the segments do.
      do_capture(8'h05, 6'h03, 1'b1, 1'b0);
      cur = sb.pop_front();
      wait_digit(1, ok);
      n_total++;
      if (!ok || seg_n !== ZSEG || dp_n !== cur.c ^ 1'b1)
         $display("FAIL lz_carry: found=%b seg=%h dp=%b want %h 0", ok, seg_n, dp_n, ZSEG);
      else n_pass++;
   endtask

   task automatic test_reset_midrun;
      bit ok;
      bit seen;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({an_n, seg_n, dp_n, valid, shown} !== {4'hF, 7'h7F, 1'b1, 1'b0, 8'h00})
         $display("FAIL midrun_reset: an=%h seg=%h dp=%b valid=%b shown=%h, want F 7f 1 0 00",
                  an_n, seg_n, dp_n, valid, shown);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      // Scan must restart from the rightmost digit.
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         if (an_n != 4'hF) begin
            seen = 1'b1;
            n_total++;
            if (an_n !== 4'hE)
               $display("FAIL restart_idx: first an_n=%h want e", an_n);
            else n_pass++;
         end
      end
      if (!seen) begin
         n_total++;
         $display("FAIL restart_idx: no digit lit, an_n=%h", an_n);
      end
      wait_digit(2, ok);
      n_total++;
      if (!ok || seg_n !== 7'h3F || dp_n !== 1'b1)
         $display("FAIL post_reset_dash: found=%b seg=%h dp=%b want 3f 1", ok, seg_n, dp_n);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; result = '0; op = '0; carry = 1'b0; zero = 1'b0; update = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_scan;
      test_capture;
      test_flags;
      test_single_capture;
      test_leading_zero;
      test_reset_midrun;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
